prm_edge_scan_ctrl: RTL and testbench

- Sequencer downstream of the per-obstacle edge checkers (`prm_oblgc_chk*`).
- Accepts a stream of 15-bit edge codes (bits A..O) and drives each code to a bank of NUM_CHK combinational checkers.
- Registers their edge_mask outputs, OR-reduces them under an obstacle-enable mask, and records one blocked/free bit per roadmap edge.
- The planner reads the resulting edge bitmap word-wise after DONE.

---
 rtl/prm_edge_scan_ctrl_pkg.sv | 27 ++
 rtl/prm_edge_scan_ctrl_if.sv | 23 ++
 rtl/prm_edge_scan_ctrl_bitmap.sv | 47 ++++
 rtl/prm_edge_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_prm_edge_scan_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/prm_edge_scan_ctrl_pkg.sv
// Shared constants, state encoding and width helpers for the roadmap edge scan
// sequencer and its bitmap store.
package prm_scan_pkg;

  localparam int CODE_W        = 15;
  localparam int DEF_NUM_CHK   = 8;
  localparam int DEF_NUM_EDGES = 1024;
  localparam int DEF_WORD_W    = 32;

  localparam int DEF_NUM_WORDS = DEF_NUM_EDGES / DEF_WORD_W;
  localparam int DEF_IDX_W     = $clog2(DEF_NUM_EDGES);
  localparam int DEF_CNT_W     = DEF_IDX_W + 1;
  // One extra code point so an out-of-range word address can be presented.
  localparam int DEF_ADDR_W    = $clog2(DEF_NUM_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  function automatic logic masked_hit(input logic [DEF_NUM_CHK-1:0] mask,
                                      input logic [DEF_NUM_CHK-1:0] en);
    return |(mask & en);
  endfunction

endpackage

// File: rtl/prm_edge_scan_ctrl_if.sv
// Edge-code stream into the scan sequencer: valid/code from the producer,
// ready back from the sequencer.
interface prm_edge_scan_ctrl_if
  import prm_scan_pkg::*;
();

  logic              in_valid;
  logic [CODE_W-1:0] in_code;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_code,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_code,
    output in_ready
  );

endinterface

// File: rtl/prm_edge_scan_ctrl_bitmap.sv
// One blocked/free bit per roadmap edge: single-bit write, whole-array clear,
// combinational word read that returns zero for addresses past the last word.
module prm_edge_bitmap
  import prm_scan_pkg::*;
#(
  parameter  int NUM_EDGES = DEF_NUM_EDGES,
  parameter  int WORD_W    = DEF_WORD_W,
  localparam int IDX_W     = $clog2(NUM_EDGES),
  localparam int NUM_WORDS = NUM_EDGES / WORD_W,
  localparam int ADDR_W    = $clog2(NUM_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic              wr_bit_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WORD_W-1:0] rd_data_o
);

  logic [NUM_EDGES-1:0] bits_q;

  // bitmap storage: clear has priority over the stage-2 write
  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q <= '0;
    end else if (clr_i) begin
      bits_q <= '0;
    end else if (wr_en_i) begin
      bits_q[wr_idx_i] <= wr_bit_i;
    end else begin
      bits_q <= bits_q;
    end
  end

  // word read port
  always_comb begin
    rd_data_o = '0;
    if (rd_addr_i < ADDR_W'(NUM_WORDS)) begin
      rd_data_o = bits_q[32'(rd_addr_i) * WORD_W +: WORD_W];
    end else begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// Edge scan sequencer: streams edge codes to the obstacle checkers, folds the
// enabled checker hits into one bit per edge and counts blocked edges.
module prm_edge_scan_ctrl
  import prm_scan_pkg::*;
#(
  parameter  int NUM_CHK   = DEF_NUM_CHK,
  parameter  int NUM_EDGES = DEF_NUM_EDGES,
  parameter  int WORD_W    = DEF_WORD_W,
  localparam int IDX_W     = $clog2(NUM_EDGES),
  localparam int CNT_W     = IDX_W + 1,
  localparam int NUM_WORDS = NUM_EDGES / WORD_W,
  localparam int ADDR_W    = $clog2(NUM_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [NUM_CHK-1:0]   obs_en_i,
  prm_edge_scan_ctrl_if.slave  in_if,
  output logic [CODE_W-1:0]    chk_code_o,
  input  logic [NUM_CHK-1:0]   chk_mask_i,
  input  logic [ADDR_W-1:0]    rd_addr_i,
  output logic [WORD_W-1:0]    rd_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     blocked_cnt_o
);

  scan_state_t        state_q, state_d;
  logic [CODE_W-1:0]  chk_code_q;
  logic               v1_q;
  logic [IDX_W-1:0]   idx1_q;
  logic [CNT_W-1:0]   acc_cnt_q;
  logic [CNT_W-1:0]   blocked_cnt_q;
  logic [NUM_CHK-1:0] en_q;

  logic in_ready;
  logic start_ok;
  logic accept;
  logic scan_end;
  logic hit;

  assign accept   = in_if.in_valid & in_ready;
  assign scan_end = (acc_cnt_q == CNT_W'(NUM_EDGES)) & ~v1_q;
  assign hit      = |(chk_mask_i & en_q);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; start is ignored while a scan is running
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = SCAN;
        else         state_d = IDLE;
      end
      SCAN: begin
        if (scan_end) state_d = DONE;
        else          state_d = SCAN;
      end
      DONE: begin
        if (start_i) state_d = SCAN;
        else         state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o   = 1'b0;
    done_o   = 1'b0;
    start_ok = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        start_ok = start_i;
      end
      SCAN: begin
        busy_o   = 1'b1;
        in_ready = (acc_cnt_q < CNT_W'(NUM_EDGES));
      end
      DONE: begin
        done_o   = 1'b1;
        start_ok = start_i;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // stage 1 (code to checkers) and stage 2 (hit accumulation) pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_code_q    <= '0;
      v1_q          <= 1'b0;
      idx1_q        <= '0;
      acc_cnt_q     <= '0;
      blocked_cnt_q <= '0;
      en_q          <= '0;
    end else if (start_ok) begin
      v1_q          <= 1'b0;
      acc_cnt_q     <= '0;
      blocked_cnt_q <= '0;
      en_q          <= obs_en_i;
    end else begin
      v1_q <= accept;
      if (accept) begin
        chk_code_q <= in_if.in_code;
        idx1_q     <= acc_cnt_q[IDX_W-1:0];
        acc_cnt_q  <= acc_cnt_q + CNT_W'(1);
      end
      if (v1_q) begin
        blocked_cnt_q <= blocked_cnt_q + {{(CNT_W-1){1'b0}}, hit};
      end
    end
  end

  prm_edge_bitmap #(
    .NUM_EDGES (NUM_EDGES),
    .WORD_W    (WORD_W)
  ) u_bitmap (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (start_ok),
    .wr_en_i   (v1_q & ~start_ok),
    .wr_idx_i  (idx1_q),
    .wr_bit_i  (hit),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o)
  );

  assign in_if.in_ready = in_ready;
  assign chk_code_o     = chk_code_q;
  assign blocked_cnt_o  = blocked_cnt_q;

endmodule

// File: tb/tb_prm_edge_scan_ctrl.sv
// Directed bench for prm_edge_scan_ctrl with a behavioural checker bank model.
module tb_prm_edge_scan_ctrl;

  localparam int NE = 1024;
  localparam int NW = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  obs_en = 8'h00;
  logic [14:0] chk_code;
  logic [7:0]  chk_mask;
  logic [5:0]  rd_addr = 6'd0;
  logic [31:0] rd_data;
  logic        busy, done;
  logic [10:0] blocked_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int mode     = 0;
  int cyc, rdy, code_err;
  logic [14:0] exp_chk = 15'd0;

  prm_edge_scan_ctrl_if in_if ();

  prm_edge_scan_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .obs_en_i      (obs_en),
    .in_if         (in_if),
    .chk_code_o    (chk_code),
    .chk_mask_i    (chk_mask),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .busy_o        (busy),
    .done_o        (done),
    .blocked_cnt_o (blocked_cnt)
  );

  always #5 clk = ~clk;

  // checker bank model: combinational in chk_code
  always_comb begin
    case (mode)
      0:       chk_mask = {8{chk_code[14]}};
      1:       chk_mask = 8'hFF;
      2:       chk_mask = {4'b0000, chk_code[14], 3'b000};
      default: chk_mask = 8'h00;
    endcase
  end

  function automatic logic [14:0] code_of(input int k);
    logic [13:0] lo;
    logic        b;
    lo = 14'(k * 37 + 5);
    b  = k[0] ^ k[5] ^ k[9];
    return {b, lo};
  endfunction

  function automatic logic exp_bit(input int k, input logic [7:0] en, input int md);
    logic [14:0] c;
    c = code_of(k);
    case (md)
      0:       return c[14] && (en != 8'h00);
      1:       return (en != 8'h00);
      2:       return c[14] && en[3];
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_scan(input int gap, input logic [7:0] en, input int md,
                          input int rst_at, input int mid_start);
    int k, phase;
    logic will_acc;
    mode = md;
    @(posedge clk); #1;
    start = 1'b1; obs_en = en; in_if.in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; obs_en = ~en;
    k = 0; phase = 0; cyc = 0; rdy = 0; code_err = 0;
    while (cyc < 5000) begin
      if (in_if.in_ready) rdy++;
      in_if.in_valid = (phase == 0);
      in_if.in_code  = code_of(k);
      start = (mid_start >= 0) && (cyc == mid_start);
      will_acc = in_if.in_valid && in_if.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (will_acc) begin
        exp_chk = code_of(k);
        k++;
      end
      if (chk_code !== exp_chk) code_err++;
      phase = (gap == 0) ? 0 : (phase + 1) % (gap + 1);
      if (rst_at >= 0 && k == rst_at) begin
        rst = 1'b1; start = 1'b0; in_if.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_chk = 15'd0;
        break;
      end
      if (done) break;
    end
    start = 1'b0;
    in_if.in_valid = 1'b0;
    check_eq("chk_code_tracking", 64'(code_err), 64'd0);
  endtask

  task automatic verify_bitmap(input string tag, input logic [7:0] en, input int md,
                               input int exp_blocked);
    logic [31:0] w;
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_blocked_cnt"}, 64'(blocked_cnt), 64'(exp_blocked));
    for (int a = 0; a < NW; a++) begin
      for (int b = 0; b < 32; b++) w[b] = exp_bit(a * 32 + b, en, md);
      rd_addr = 6'(a);
      #1;
      check_eq($sformatf("%s_word%0d", tag, a), 64'(rd_data), 64'(w));
    end
  endtask

  initial begin
    int err;
    in_if.in_valid = 1'b0;
    in_if.in_code  = 15'd0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;

    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_ready", 64'(in_if.in_ready), 64'd0);
    check_eq("rst_chk_code", 64'(chk_code), 64'd0);
    check_eq("rst_blocked", 64'(blocked_cnt), 64'd0);
    rd_addr = 6'd0; #1;
    check_eq("rst_word0", 64'(rd_data), 64'd0);

    // back-to-back, all checkers enabled, bit14 codes blocked
    run_scan(0, 8'hFF, 0, -1, -1);
    check_eq("a_done_cycle", 64'(cyc), 64'd1026);
    check_eq("a_ready_cycles", 64'(rdy), 64'd1024);
    check_eq("a_blocked_512", 64'(blocked_cnt), 64'd512);
    verify_bitmap("a", 8'hFF, 0, 512);

    // no checkers enabled while every checker asserts
    run_scan(0, 8'h00, 1, -1, -1);
    check_eq("b_done_cycle", 64'(cyc), 64'd1026);
    verify_bitmap("b", 8'h00, 1, 0);

    // gapped stream: 1 valid, 2 idle
    run_scan(2, 8'hFF, 0, -1, -1);
    verify_bitmap("c", 8'hFF, 0, 512);

    // only checker 3 asserts
    run_scan(0, 8'b0000_1000, 2, -1, -1);
    verify_bitmap("d", 8'b0000_1000, 2, 512);
    run_scan(0, 8'b1111_0111, 2, -1, -1);
    verify_bitmap("e", 8'b1111_0111, 2, 0);

    // reset at edge 500 mid-scan
    run_scan(0, 8'hFF, 0, 500, -1);
    check_eq("r_busy", 64'(busy), 64'd0);
    check_eq("r_done", 64'(done), 64'd0);
    check_eq("r_ready", 64'(in_if.in_ready), 64'd0);
    check_eq("r_chk_code", 64'(chk_code), 64'd0);
    check_eq("r_blocked", 64'(blocked_cnt), 64'd0);
    err = 0;
    for (int a = 0; a < NW; a++) begin
      rd_addr = 6'(a); #1;
      if (rd_data !== 32'd0) err++;
    end
    check_eq("r_bitmap_clear", 64'(err), 64'd0);

    // normal scan after reset, with a start pulse mid-scan
    run_scan(0, 8'hFF, 0, -1, 300);
    check_eq("g_done_cycle", 64'(cyc), 64'd1026);
    verify_bitmap("g", 8'hFF, 0, 512);
    rd_addr = 6'd32; #1;
    check_eq("oob_rd_data", 64'(rd_data), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
